// File: rtl/hs32_opfetch_if.sv
// Bus bundle between hs32_opfetch and its neighbours: decode requests, execute writebacks,
// the dual-port register file, and the downstream operand consumer.
interface hs32_opfetch_if #(
    parameter int addr_width = 4,
    parameter int data_width = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [addr_width-1:0] req_rs1;
    logic [addr_width-1:0] req_rs2;
    logic                  wb_valid;
    logic [addr_width-1:0] wb_adr;
    logic [data_width-1:0] wb_data;
    logic                  rf_we;
    logic [addr_width-1:0] rf_wadr;
    logic [data_width-1:0] rf_din;
    logic [addr_width-1:0] rf_radr1;
    logic [addr_width-1:0] rf_radr2;
    logic [data_width-1:0] rf_dout1;
    logic [data_width-1:0] rf_dout2;
    logic                  op_valid;
    logic                  op_ready;
    logic [data_width-1:0] op_a;
    logic [data_width-1:0] op_b;

    modport slave (
        input  req_valid, req_rs1, req_rs2,
        input  wb_valid, wb_adr, wb_data,
        input  rf_dout1, rf_dout2,
        input  op_ready,
        output req_ready,
        output rf_we, rf_wadr, rf_din, rf_radr1, rf_radr2,
        output op_valid, op_a, op_b
    );

    modport master (
        output req_valid, req_rs1, req_rs2,
        output wb_valid, wb_adr, wb_data,
        output rf_dout1, rf_dout2,
        output op_ready,
        input  req_ready,
        input  rf_we, rf_wadr, rf_din, rf_radr1, rf_radr2,
        input  op_valid, op_a, op_b
    );
endinterface

// File: rtl/hs32_opfetch.sv
// Operand-fetch / writeback controller for the hs32 register file: schedules reads around
// writebacks and keeps the captured operand pair coherent with later commits.
module hs32_opfetch #(
    parameter int addr_width = 4,
    parameter int data_width = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    hs32_opfetch_if.slave        io_bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]            r_state;
    logic [addr_width-1:0] r_rs1;
    logic [addr_width-1:0] r_rs2;
    logic [data_width-1:0] r_op_a;
    logic [data_width-1:0] r_op_b;
    logic                  r_op_valid;

    logic [1:0]            w_state_nxt;
    logic [addr_width-1:0] w_rs1_nxt;
    logic [addr_width-1:0] w_rs2_nxt;
    logic [data_width-1:0] w_op_a_nxt;
    logic [data_width-1:0] w_op_b_nxt;
    logic                  w_op_valid_nxt;
    logic                  w_fwd_a;
    logic                  w_fwd_b;

    // A commit this cycle that targets a latched source must override the file's stale copy
    assign w_fwd_a = io_bus.wb_valid && (io_bus.wb_adr == r_rs1);
    assign w_fwd_b = io_bus.wb_valid && (io_bus.wb_adr == r_rs2);

    // Next-state and next-operand selection
    always_comb begin
        w_state_nxt    = r_state;
        w_rs1_nxt      = r_rs1;
        w_rs2_nxt      = r_rs2;
        w_op_a_nxt     = r_op_a;
        w_op_b_nxt     = r_op_b;
        w_op_valid_nxt = r_op_valid;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.req_valid) begin
                    w_rs1_nxt   = io_bus.req_rs1;
                    w_rs2_nxt   = io_bus.req_rs2;
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // The file only reads on edges without a write, so a writeback holds us here
                if (io_bus.wb_valid) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_fwd_a) begin
                    w_op_a_nxt = io_bus.wb_data;
                end else begin
                    w_op_a_nxt = io_bus.rf_dout1;
                end
                if (w_fwd_b) begin
                    w_op_b_nxt = io_bus.wb_data;
                end else begin
                    w_op_b_nxt = io_bus.rf_dout2;
                end
                w_op_valid_nxt = 1'b1;
                w_state_nxt    = ST_HOLD;
            end
            ST_HOLD: begin
                // A handshake transfers the value already held; a same-cycle commit is dropped
                if (io_bus.op_ready) begin
                    w_op_valid_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    if (w_fwd_a) begin
                        w_op_a_nxt = io_bus.wb_data;
                    end else begin
                        w_op_a_nxt = r_op_a;
                    end
                    if (w_fwd_b) begin
                        w_op_b_nxt = io_bus.wb_data;
                    end else begin
                        w_op_b_nxt = r_op_b;
                    end
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_op_valid_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    // State, latched addresses and operand registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rs1      <= {addr_width{1'b0}};
            r_rs2      <= {addr_width{1'b0}};
            r_op_a     <= {data_width{1'b0}};
            r_op_b     <= {data_width{1'b0}};
            r_op_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rs1      <= w_rs1_nxt;
            r_rs2      <= w_rs2_nxt;
            r_op_a     <= w_op_a_nxt;
            r_op_b     <= w_op_b_nxt;
            r_op_valid <= w_op_valid_nxt;
        end
    end

    assign io_bus.req_ready = (r_state == ST_IDLE) && !reset;
    assign io_bus.rf_we     = io_bus.wb_valid && !reset;
    assign io_bus.rf_wadr   = io_bus.wb_adr;
    assign io_bus.rf_din    = io_bus.wb_data;
    assign io_bus.rf_radr1  = r_rs1;
    assign io_bus.rf_radr2  = r_rs2;
    assign io_bus.op_valid  = r_op_valid;
    assign io_bus.op_a      = r_op_a;
    assign io_bus.op_b      = r_op_b;

endmodule

// File: tb/tb_hs32_opfetch.sv
// Scoreboard bench for hs32_opfetch with a behavioural register file and an architectural
// reference array of committed register values.
module tb_hs32_opfetch;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hs32_opfetch_if #(.addr_width(4), .data_width(32)) bus ();

    hs32_opfetch #(.addr_width(4), .data_width(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    typedef struct {
        logic        fixed;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] rf_mem[16];
    logic [31:0] arch[16];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic fixed, input logic [3:0] r1, input logic [3:0] r2,
                            input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.fixed = fixed;
        e.rs1   = r1;
        e.rs2   = r2;
        e.a     = a;
        e.b     = b;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register file model (reads only on write-free edges) plus the architectural reference
    initial begin
        for (int i = 0; i < 16; i++) begin
            rf_mem[i] <= 32'h1111_1111 * i;
            arch[i]   <= 32'h1111_1111 * i;
        end
        bus.rf_dout1 <= 32'h0;
        bus.rf_dout2 <= 32'h0;
        forever begin
            @(posedge clk);
            if (bus.rf_we) begin
                rf_mem[bus.rf_wadr] <= bus.rf_din;
            end else begin
                bus.rf_dout1 <= rf_mem[bus.rf_radr1];
                bus.rf_dout2 <= rf_mem[bus.rf_radr2];
            end
            if (!reset && bus.wb_valid) begin
                arch[bus.wb_adr] <= bus.wb_data;
            end
        end
    end

    // Monitor: every operand handshake pops one expected entry
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.op_valid && bus.op_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_handshake: got op_a=%h op_b=%h, expected no transfer",
                         bus.op_a, bus.op_b);
            end else begin
                e = sb_q.pop_front();
                if (!e.fixed) begin
                    e.a = arch[e.rs1];
                    e.b = arch[e.rs2];
                end
                check("xfer_op_a", bus.op_a, e.a);
                check("xfer_op_b", bus.op_b, e.b);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_rs1   = 4'd0;
        bus.req_rs2   = 4'd0;
        bus.op_ready  = 1'b0;
        bus.wb_valid  = 1'b1;
        bus.wb_adr    = 4'd9;
        bus.wb_data   = 32'hBAD0_0009;
        repeat (3) tick();
        check("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
        check("rst_op_a", bus.op_a, 32'd0);
        check("rst_op_b", bus.op_b, 32'd0);
        check("rst_radr", {24'd0, bus.rf_radr1, bus.rf_radr2}, 32'd0);
        bus.wb_valid = 1'b0;
        reset        = 1'b0;
        #1;
        check("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();

        // Write r3, then fetch r3/r0 and trace the minimum latency
        bus.wb_valid = 1'b1;
        bus.wb_adr   = 4'd3;
        bus.wb_data  = 32'h1122_3344;
        #1;
        check("wb_rf_we", {31'd0, bus.rf_we}, 32'd1);
        check("wb_rf_wadr", {28'd0, bus.rf_wadr}, 32'd3);
        check("wb_rf_din", bus.rf_din, 32'h1122_3344);
        tick();
        bus.wb_valid  = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_rs1   = 4'd3;
        bus.req_rs2   = 4'd0;
        push_exp(1'b1, 4'd3, 4'd0, 32'h1122_3344, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        check("t1_issue_ready", {31'd0, bus.req_ready}, 32'd0);
        check("t1_issue_valid", {31'd0, bus.op_valid}, 32'd0);
        tick();
        check("t1_wait_valid", {31'd0, bus.op_valid}, 32'd0);
        tick();
        check("t1_hold_valid", {31'd0, bus.op_valid}, 32'd1);
        check("t1_hold_ready", {31'd0, bus.req_ready}, 32'd0);
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;
        check("t1_after_valid", {31'd0, bus.op_valid}, 32'd0);
        check("t1_after_ready", {31'd0, bus.req_ready}, 32'd1);

        // Writebacks to r7 stall ISSUE for four cycles
        bus.req_valid = 1'b1;
        bus.req_rs1   = 4'd5;
        bus.req_rs2   = 4'd6;
        push_exp(1'b1, 4'd5, 4'd6, 32'h5555_5555, 32'h6666_6666);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.wb_valid = 1'b1;
            bus.wb_adr   = 4'd7;
            bus.wb_data  = 32'h7777_0000 + i;
            #1;
            check("t2_stall_we", {31'd0, bus.rf_we}, 32'd1);
            check("t2_stall_valid", {31'd0, bus.op_valid}, 32'd0);
            tick();
        end
        bus.wb_valid = 1'b0;
        tick();
        check("t2_wait_valid", {31'd0, bus.op_valid}, 32'd0);
        tick();
        check("t2_hold_valid", {31'd0, bus.op_valid}, 32'd1);
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;

        // rs1 == rs2 == r4, forwarded during WAIT
        bus.wb_valid = 1'b1;
        bus.wb_adr   = 4'd4;
        bus.wb_data  = 32'hA;
        tick();
        bus.wb_valid  = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_rs1   = 4'd4;
        bus.req_rs2   = 4'd4;
        push_exp(1'b1, 4'd4, 4'd4, 32'hB, 32'hB);
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.wb_valid = 1'b1;
        bus.wb_adr   = 4'd4;
        bus.wb_data  = 32'hB;
        tick();
        bus.wb_valid = 1'b0;
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;

        // HOLD forwarding, then a handshake that must discard a same-cycle commit
        bus.req_valid = 1'b1;
        bus.req_rs1   = 4'd5;
        bus.req_rs2   = 4'd6;
        push_exp(1'b1, 4'd5, 4'd6, 32'hDEAD_BEEF, 32'h6666_6666);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        check("t4_hold_a", bus.op_a, 32'h5555_5555);
        bus.wb_valid = 1'b1;
        bus.wb_adr   = 4'd5;
        bus.wb_data  = 32'hDEAD_BEEF;
        tick();
        check("t4_fwd_a", bus.op_a, 32'hDEAD_BEEF);
        check("t4_keep_b", bus.op_b, 32'h6666_6666);
        check("t4_fwd_valid", {31'd0, bus.op_valid}, 32'd1);
        bus.op_ready = 1'b1;
        bus.wb_data  = 32'h1;
        tick();
        bus.op_ready = 1'b0;
        bus.wb_valid = 1'b0;
        check("t4_idle_valid", {31'd0, bus.op_valid}, 32'd0);
        check("t4_idle_keep_a", bus.op_a, 32'hDEAD_BEEF);

        // Asynchronous reset while holding a valid pair
        bus.req_valid = 1'b1;
        bus.req_rs1   = 4'd1;
        bus.req_rs2   = 4'd2;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        check("t5_hold_valid", {31'd0, bus.op_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_valid", {31'd0, bus.op_valid}, 32'd0);
        check("t5_rst_a", bus.op_a, 32'd0);
        check("t5_rst_b", bus.op_b, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("t5_rel_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();
        check("t5_rel_valid", {31'd0, bus.op_valid}, 32'd0);
        check("t5_rel_ready2", {31'd0, bus.req_ready}, 32'd1);

        // Back-to-back requests with random writeback traffic
        bus.op_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            bus.req_valid = 1'b1;
            bus.req_rs1   = 4'($urandom_range(0, 15));
            bus.req_rs2   = 4'($urandom_range(0, 15));
            bus.wb_valid  = ($urandom_range(0, 3) == 0);
            bus.wb_adr    = 4'($urandom_range(0, 15));
            bus.wb_data   = $urandom;
            #1;
            if (bus.req_ready) begin
                push_exp(1'b0, bus.req_rs1, bus.req_rs2, 32'h0, 32'h0);
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.wb_valid  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (sb_q.size() != 0) begin
                tick();
            end
        end
        check("drain_pending", sb_q.size(), 32'd0);
        bus.op_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hs32_opfetch.md
Name: hs32_opfetch

Overview:
Operand-fetch and writeback controller that sits directly in front of the hs32 dual-port register file and is the only block driving it. It accepts operand-read requests (two source register addresses) from decode and writeback commits from execute/memory. It sequences register-file reads around writes, which take priority, and presents the captured operand pair downstream with a valid/ready handshake. Held operands are kept coherent with writebacks that commit after the read.

Parameters:
addr_width, 4, register address width
data_width, 32, register data width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  decode has an operand request
req_ready  out  1  block can accept a request
req_rs1  in  addr_width  source register A address
req_rs2  in  addr_width  source register B address
wb_valid  in  1  writeback commit this cycle; always accepted
wb_adr  in  addr_width  writeback register address
wb_data  in  data_width  writeback data
rf_we  out  1  register-file write enable
rf_wadr  out  addr_width  register-file write address
rf_din  out  data_width  register-file write data
rf_radr1  out  addr_width  register-file read address 1
rf_radr2  out  addr_width  register-file read address 2
rf_dout1  in  data_width  register-file read data 1
rf_dout2  in  data_width  register-file read data 2
op_valid  out  1  operand pair valid
op_ready  in  1  downstream accepts operands
op_a  out  data_width  operand A (value of rs1)
op_b  out  data_width  operand B (value of rs2)

Behaviour:
- Reset is asynchronous and active-high. Clock is clk; reset is reset.
- On reset: state IDLE; op_valid=0; op_a=op_b=0; latched rs1/rs2=0; rf_radr1=rf_radr2=0.
- While reset is high: rf_we=0 and req_ready=0.
- Reset asserted mid-operation discards any in-flight request. No stale op_valid may appear after reset is released.
- Register-file model: a read is registered and occurs only on an edge where rf_we=0. rf_dout1/2 are valid the cycle after the read is issued and hold their value while rf_we=1.
- Write path is combinational passthrough: rf_we=wb_valid, rf_wadr=wb_adr, rf_din=wb_data.
- Writebacks are never stalled; at most one per cycle.
- rf_radr1/rf_radr2 are driven from the registered latched rs1/rs2.
- States:
  - IDLE: req_ready=1. On req_valid: latch rs1/rs2 and go to ISSUE.
  - ISSUE: if wb_valid, stall in ISSUE (write has priority). Otherwise the read occurs at this edge; go to WAIT.
  - WAIT: capture op_a=rf_dout1 and op_b=rf_dout2 at the end of the cycle, then go to HOLD. If wb_valid and wb_adr matches rs1 (or rs2), capture wb_data for that operand instead. Match each operand independently; when rs1==rs2 both are forwarded.
  - HOLD: op_valid=1. Each cycle with wb_valid and a matching address, overwrite the matching operand(s) with wb_data. On op_ready, go to IDLE and set op_valid=0 next cycle.
- If op_ready and a matching wb_valid occur in the same HOLD cycle, the pre-update value is transferred. The update is discarded.
- req_ready=0 in ISSUE, WAIT and HOLD. No request is accepted in the same cycle an operand handshake completes.
- Minimum request-to-op_valid latency: 3 cycles (accept edge, read edge, capture edge).
- Throughput: at most one request per 4 cycles.
- Continuous wb_valid starves ISSUE indefinitely. This is by design; upstream bounds it.
- op_a/op_b stay stable in HOLD except for forwarding updates.
- op_a/op_b retain their last value in IDLE.

Test Plan:
- Reset, then write r3=0x11223344 via wb, then request rs1=3, rs2=0 -> op_valid 3 cycles after accept with op_a=0x11223344, op_b=0; req_ready low until the cycle after the op handshake.
- Request rs1=5, rs2=6 with wb_valid held high for 4 cycles writing r7 during ISSUE -> ISSUE stalls 4 cycles, rf_we=1 each of those cycles, read issues afterwards, and the operands equal the prior r5/r6 contents.
- Request rs1=rs2=4 (r4=0xA); in the WAIT cycle, wb r4=0xB -> op_a=op_b=0xB.
- In HOLD with op_ready=0, wb r5=0xDEADBEEF where rs1=5 -> op_a updates to 0xDEADBEEF next cycle while op_b is unchanged. In the same HOLD with op_ready=1 and wb r5=0x1 together -> 0xDEADBEEF is transferred.
- Assert reset asynchronously in HOLD with op_valid=1 -> op_valid, op_a and op_b go 0 immediately; req_ready=1 the first cycle after release.
- Back-to-back requests with op_ready tied high, randomized wb traffic, compared against a reference register array -> every transferred operand equals the architectural value at the handshake cycle.
